// File: rtl/wb_chan_fanout_if.sv
// Bus bundle for wb_chan_fanout: upstream Wishbone target side
// plus the shared/per-channel downstream initiator side.
interface wb_chan_fanout_if #(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_WIDTH   = 22,
  parameter int DATA_WIDTH   = 32,
  parameter int CHAN_LSB     = 8
);
  logic                           wb_s_cyc_i;
  logic                           wb_s_stb_i;
  logic                           wb_s_we_i;
  logic [ADDR_WIDTH-1:0]          wb_s_adr_i;
  logic [DATA_WIDTH-1:0]          wb_s_dat_i;
  logic [DATA_WIDTH/8-1:0]        wb_s_sel_i;
  logic [DATA_WIDTH-1:0]          wb_s_dat_o;
  logic                           wb_s_ack_o;
  logic                           wb_s_err_o;
  logic                           wb_s_rty_o;

  logic [NUM_CHANNELS-1:0]        wb_m_cyc_o;
  logic [NUM_CHANNELS-1:0]        wb_m_stb_o;
  logic                           wb_m_we_o;
  logic [CHAN_LSB-1:0]            wb_m_adr_o;
  logic [DATA_WIDTH-1:0]          wb_m_dat_o;
  logic [DATA_WIDTH/8-1:0]        wb_m_sel_o;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] wb_m_dat_i;
  logic [NUM_CHANNELS-1:0]        wb_m_ack_i;
  logic [NUM_CHANNELS-1:0]        wb_m_err_i;
  logic [NUM_CHANNELS-1:0]        wb_m_rty_i;

  modport slave (
    input  wb_s_cyc_i, wb_s_stb_i, wb_s_we_i,
    input  wb_s_adr_i, wb_s_dat_i, wb_s_sel_i,
    output wb_s_dat_o, wb_s_ack_o, wb_s_err_o, wb_s_rty_o,
    output wb_m_cyc_o, wb_m_stb_o, wb_m_we_o,
    output wb_m_adr_o, wb_m_dat_o, wb_m_sel_o,
    input  wb_m_dat_i, wb_m_ack_i, wb_m_err_i, wb_m_rty_i
  );

  modport master (
    output wb_s_cyc_i, wb_s_stb_i, wb_s_we_i,
    output wb_s_adr_i, wb_s_dat_i, wb_s_sel_i,
    input  wb_s_dat_o, wb_s_ack_o, wb_s_err_o, wb_s_rty_o,
    input  wb_m_cyc_o, wb_m_stb_o, wb_m_we_o,
    input  wb_m_adr_o, wb_m_dat_o, wb_m_sel_o,
    output wb_m_dat_i, wb_m_ack_i, wb_m_err_i, wb_m_rty_i
  );
endinterface

// File: rtl/wb_chan_fanout.sv
// Registered Wishbone fan-out, one target to NUM_CHANNELS initiators.
// Optional broadcast write (all-ones index): WB_FANOUT_BROADCAST_EN.
module wb_chan_fanout #(
  parameter int NUM_CHANNELS   = 8,
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int CHAN_LSB       = 8,
  parameter int CHAN_BITS      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             wb_clk_i,
  input logic             wb_rst_ni,
  wb_chan_fanout_if.slave bus
);
  localparam int NC = NUM_CHANNELS;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {RSP_ACK, RSP_ERR, RSP_RTY} rsp_t;

  state_t               r_state, w_state;
  rsp_t                 r_rsp, w_rsp;
  logic [NC-1:0]        r_mask, w_mask;
  logic [TW-1:0]        r_timer, w_timer;
  logic                 r_err, w_err;
  logic                 r_rty, w_rty;
  logic                 r_bcast, w_bcast;
  logic [CHAN_BITS-1:0] r_idx, w_idx_q;
  logic [CHAN_LSB-1:0]  r_adr, w_adr;
  logic [DW-1:0]        r_wdat, w_wdat;
  logic [DW-1:0]        r_rdat, w_rdat;
  logic [SW-1:0]        r_sel, w_sel;
  logic                 r_we, w_we;

  logic [CHAN_BITS-1:0] w_idx;
  logic [NC-1:0]        w_onehot;
  logic [NC-1:0]        w_ackc, w_errc, w_rtyc, w_hit;
  logic [DW-1:0]        w_chdat;
  logic                 w_req, w_inrange, w_bc_hit, w_tmo;
  logic                 w_unused;

  assign w_idx     = bus.wb_s_adr_i[CHAN_LSB +: CHAN_BITS];
  assign w_req     = bus.wb_s_cyc_i & bus.wb_s_stb_i;
  assign w_inrange = int'(w_idx) < NC;
  assign w_tmo     = (r_timer == TW'(TIMEOUT_CYCLES - 1));
  // Address bits above the channel field are don't-care.
  assign w_unused  = ^bus.wb_s_adr_i;

`ifdef WB_FANOUT_BROADCAST_EN
  assign w_bc_hit = (&w_idx) & bus.wb_s_we_i;
`else
  assign w_bc_hit = 1'b0;
`endif

  // Per-channel response after ack > err > rty priority, pending only.
  assign w_ackc = bus.wb_m_ack_i & r_mask;
  assign w_errc = bus.wb_m_err_i & r_mask & ~bus.wb_m_ack_i;
  assign w_rtyc = bus.wb_m_rty_i & r_mask
                & ~bus.wb_m_ack_i & ~bus.wb_m_err_i;
  assign w_hit  = w_ackc | w_errc | w_rtyc;

  // Channel decode and read-data mux for the latched index.
  always_comb begin
    w_onehot = '0;
    w_chdat  = '0;
    for (int k = 0; k < NC; k++) begin
      w_onehot[k] = (w_idx == CHAN_BITS'(k));
      if (r_idx == CHAN_BITS'(k))
        w_chdat = bus.wb_m_dat_i[k*DW +: DW];
    end
  end

  // Next-state: accept, wait for the pending mask to drain, respond.
  always_comb begin
    w_state = r_state;
    w_rsp   = r_rsp;
    w_mask  = r_mask;
    w_timer = r_timer;
    w_err   = r_err;
    w_rty   = r_rty;
    w_bcast = r_bcast;
    w_idx_q = r_idx;
    w_adr   = r_adr;
    w_wdat  = r_wdat;
    w_rdat  = r_rdat;
    w_sel   = r_sel;
    w_we    = r_we;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_idx_q = w_idx;
          w_adr   = bus.wb_s_adr_i[CHAN_LSB-1:0];
          w_wdat  = bus.wb_s_dat_i;
          w_sel   = bus.wb_s_sel_i;
          w_we    = bus.wb_s_we_i;
          w_timer = '0;
          w_err   = 1'b0;
          w_rty   = 1'b0;
          w_bcast = w_bc_hit;
          if (w_bc_hit) begin
            w_mask  = '1;
            w_state = REQ;
          end else if (w_inrange) begin
            w_mask  = w_onehot;
            w_state = REQ;
          end else begin
            w_state = RESP;
            w_rsp   = RSP_ERR;
            w_rdat  = '0;
          end
        end
      end
      REQ: begin
        if (!bus.wb_s_cyc_i) begin
          w_state = IDLE;
          w_mask  = '0;
        end else begin
          w_mask  = r_mask & ~w_hit;
          w_err   = r_err | (|w_errc);
          w_rty   = r_rty | (|w_rtyc);
          w_timer = r_timer + 1'b1;
          if (w_mask == '0) begin
            w_state = RESP;
            w_rsp   = w_err ? RSP_ERR
                    : w_rty ? RSP_RTY : RSP_ACK;
            w_rdat  = r_bcast ? '0 : w_chdat;
          end else if (w_tmo) begin
            w_state = RESP;
            w_rsp   = RSP_ERR;
            w_mask  = '0;
            w_rdat  = '0;
          end
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  // State and latched transaction fields.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_rsp   <= RSP_ACK;
      r_mask  <= '0;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_bcast <= 1'b0;
      r_idx   <= '0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_rsp   <= w_rsp;
      r_mask  <= w_mask;
      r_timer <= w_timer;
      r_err   <= w_err;
      r_rty   <= w_rty;
      r_bcast <= w_bcast;
      r_idx   <= w_idx_q;
      r_adr   <= w_adr;
      r_wdat  <= w_wdat;
      r_rdat  <= w_rdat;
      r_sel   <= w_sel;
      r_we    <= w_we;
    end
  end

  assign bus.wb_m_cyc_o = r_mask;
  assign bus.wb_m_stb_o = r_mask;
  assign bus.wb_m_we_o  = r_we;
  assign bus.wb_m_adr_o = r_adr;
  assign bus.wb_m_dat_o = r_wdat;
  assign bus.wb_m_sel_o = r_sel;
  assign bus.wb_s_dat_o = r_rdat;
  assign bus.wb_s_ack_o = (r_state == RESP) && (r_rsp == RSP_ACK);
  assign bus.wb_s_err_o = (r_state == RESP) && (r_rsp == RSP_ERR);
  assign bus.wb_s_rty_o = (r_state == RESP) && (r_rsp == RSP_RTY);
endmodule
